// File: rtl/mem_port_arbiter_if.sv
// Bundle of per-port request channels and the shared memory channels seen by mem_port_arbiter.
// The master view belongs to the arbiter; the slave view to the requesters and memory adapter.
interface mem_port_arbiter_if #(
  parameter int num_ports = 4,
  parameter int mem_width = 32,
  parameter int cmd_width = 65
);
  logic [num_ports-1:0] req_cmd_valid;
  logic [num_ports-1:0] req_cmd_ready;
  logic [cmd_width-1:0] req_cmd_data [num_ports];

  logic [num_ports-1:0] req_wr_valid;
  logic [num_ports-1:0] req_wr_ready;
  logic [mem_width-1:0] req_wr_data [num_ports];

  logic [num_ports-1:0] req_rd_valid;
  logic [num_ports-1:0] req_rd_ready;
  logic [mem_width-1:0] req_rd_data;

  logic                 mem_cmd_valid;
  logic                 mem_cmd_ready;
  logic [cmd_width-1:0] mem_cmd_data;

  logic                 mem_write_valid;
  logic                 mem_write_ready;
  logic [mem_width-1:0] mem_write_data;

  logic                 mem_read_valid;
  logic                 mem_read_ready;
  logic [mem_width-1:0] mem_read_data;

  modport master (
    input  req_cmd_valid, req_cmd_data,
    output req_cmd_ready,
    input  req_wr_valid, req_wr_data,
    output req_wr_ready,
    output req_rd_valid, req_rd_data,
    input  req_rd_ready,
    output mem_cmd_valid, mem_cmd_data,
    input  mem_cmd_ready,
    output mem_write_valid, mem_write_data,
    input  mem_write_ready,
    input  mem_read_valid, mem_read_data,
    output mem_read_ready
  );

  modport slave (
    output req_cmd_valid, req_cmd_data,
    input  req_cmd_ready,
    output req_wr_valid, req_wr_data,
    input  req_wr_ready,
    input  req_rd_valid, req_rd_data,
    output req_rd_ready,
    input  mem_cmd_valid, mem_cmd_data,
    output mem_cmd_ready,
    input  mem_write_valid, mem_write_data,
    output mem_write_ready,
    output mem_read_valid, mem_read_data,
    input  mem_read_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory command/write/read channel set among num_ports requesters.
// One transaction at a time; data phases are pure combinational passthrough of the granted port.
module mem_port_arbiter #(
  parameter int num_ports = 4,
  parameter int mem_width = 32,
  parameter int cmd_width = 65,
  localparam int id_w = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.master  bus,
  output logic                busy,
  output logic [id_w-1:0]     grant_id
);

  localparam int sum_w = id_w + 1;

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t            state, state_nxt;
  logic [id_w-1:0]   rr_ptr, rr_nxt;
  logic [id_w-1:0]   grant_nxt;
  logic [31:0]       count, count_nxt;

  logic              arb_found;
  logic [id_w-1:0]   arb_pick;
  logic [sum_w-1:0]  arb_sum;

  logic [cmd_width-1:0] cmd_sel;
  logic [mem_width-1:0] wr_sel;
  logic [31:0]          cmd_len;
  logic                 cmd_is_read;
  logic                 last_word;

  assign cmd_sel     = bus.req_cmd_data[grant_id];
  assign wr_sel      = bus.req_wr_data[grant_id];
  assign cmd_len     = cmd_sel[31:0];
  assign cmd_is_read = cmd_sel[cmd_width-1];
  assign last_word   = (count == 32'd1);
  assign busy        = (state != IDLE);

  // First requesting port at or after rr_ptr, wrapping modulo num_ports.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_sum   = '0;
    for (int i = 0; i < num_ports; i++) begin
      arb_sum = {1'b0, rr_ptr} + sum_w'(i);
      if (arb_sum >= sum_w'(num_ports)) begin
        arb_sum = arb_sum - sum_w'(num_ports);
      end
      if (!arb_found && bus.req_cmd_valid[arb_sum[id_w-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = arb_sum[id_w-1:0];
      end
    end
  end

  // Outputs are also squelched while reset_n is low so an abandoned transfer
  // cannot complete a handshake in the reset cycle itself.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant_id;
    count_nxt = count;

    bus.req_cmd_ready   = '0;
    bus.req_wr_ready    = '0;
    bus.req_rd_valid    = '0;
    bus.req_rd_data     = '0;
    bus.mem_cmd_valid   = 1'b0;
    bus.mem_cmd_data    = '0;
    bus.mem_write_valid = 1'b0;
    bus.mem_write_data  = '0;
    bus.mem_read_ready  = 1'b0;

    if (reset_n) begin
      unique case (state)
        IDLE: begin
          if (arb_found) begin
            grant_nxt = arb_pick;
            state_nxt = CMD;
          end
        end

        CMD: begin
          bus.mem_cmd_valid           = 1'b1;
          bus.mem_cmd_data            = cmd_sel;
          bus.req_cmd_ready[grant_id] = bus.mem_cmd_ready;
          if (bus.mem_cmd_ready) begin
            count_nxt = cmd_len;
            rr_nxt    = (grant_id == id_w'(num_ports - 1)) ? '0 : grant_id + 1'b1;
            if (cmd_len == 32'd0) begin
              state_nxt = IDLE;
            end else if (cmd_is_read) begin
              state_nxt = READ;
            end else begin
              state_nxt = WRITE;
            end
          end
        end

        WRITE: begin
          bus.mem_write_valid        = bus.req_wr_valid[grant_id];
          bus.mem_write_data         = wr_sel;
          bus.req_wr_ready[grant_id] = bus.mem_write_ready;
          if (bus.req_wr_valid[grant_id] && bus.mem_write_ready) begin
            count_nxt = count - 32'd1;
            if (last_word) state_nxt = IDLE;
          end
        end

        READ: begin
          bus.req_rd_valid[grant_id] = bus.mem_read_valid;
          bus.req_rd_data            = bus.mem_read_data;
          bus.mem_read_ready         = bus.req_rd_ready[grant_id];
          if (bus.mem_read_valid && bus.req_rd_ready[grant_id]) begin
            count_nxt = count - 32'd1;
            if (last_word) state_nxt = IDLE;
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= grant_nxt;
      count    <= count_nxt;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter num_ports, default 4: number of requester ports sharing one memory command/write/read channel set.
REQ-002 SHALL have parameter mem_width, default 32: width of write and read data words.
REQ-003 SHALL have parameter cmd_width, default 65: command word layout is bit 64 = read (1) / write (0), bits 63:32 = word address, bits 31:0 = length in words.
REQ-004 SHALL have port clk  in  1: single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset_n  in  1: synchronous, active-low reset.
REQ-006 SHALL have ports req_cmd_valid / req_cmd_ready / req_cmd_data  in / out / in  num_ports / num_ports / num_ports x cmd_width: per-port command channel.
REQ-007 SHALL have ports req_wr_valid / req_wr_ready / req_wr_data  in / out / in  num_ports / num_ports / num_ports x mem_width: per-port write data.
REQ-008 SHALL have ports req_rd_valid / req_rd_ready / req_rd_data  out / in / out  num_ports / num_ports / mem_width (shared data bus): per-port read return.
REQ-009 SHALL have ports mem_cmd_valid / mem_cmd_ready / mem_cmd_data  out / in / out  1 / 1 / cmd_width: command to memory adapter.
REQ-010 SHALL have ports mem_write_valid / mem_write_ready / mem_write_data  out / in / out  1 / 1 / mem_width: write data to memory adapter.
REQ-011 SHALL have ports mem_read_valid / mem_read_ready / mem_read_data  in / out / in  1 / 1 / mem_width: read data from memory adapter.
REQ-012 SHALL have ports busy  out  1 (state != IDLE) and grant_id  out  clog2(num_ports) (currently granted port).

Function
REQ-013 SHALL implement states IDLE, CMD, WRITE, READ; exactly one transaction in flight at any time.
REQ-014 SHALL, in IDLE, select the first port with req_cmd_valid at index >= rr_ptr, wrapping modulo num_ports, register it into grant_id and enter CMD next cycle; no request -> stay IDLE.
REQ-015 SHALL, in CMD, drive mem_cmd_valid=1 and mem_cmd_data=req_cmd_data[grant_id]; req_cmd_ready[grant_id]=mem_cmd_ready combinationally; all other req_cmd_ready=0.
REQ-016 SHALL, on CMD handshake, load word counter with length field, set rr_ptr=(grant_id+1) mod num_ports, and go to READ (bit 64=1) or WRITE (bit 64=0); length=0 -> IDLE directly, no data phase.
REQ-017 SHALL, in WRITE, pass mem_write_valid=req_wr_valid[grant_id], mem_write_data=req_wr_data[grant_id], req_wr_ready[grant_id]=mem_write_ready; decrement counter per handshake; handshake with counter=1 -> IDLE.
REQ-018 SHALL, in READ, pass req_rd_valid[grant_id]=mem_read_valid, req_rd_data=mem_read_data, mem_read_ready=req_rd_ready[grant_id]; decrement per handshake; handshake with counter=1 -> IDLE.
REQ-019 SHALL hold every non-granted port's ready/valid outputs at 0 in all states, and hold all mem_* valid and mem_read_ready at 0 outside their owning state.
REQ-020 SHALL add zero latency on data passthrough (combinational valid/ready/data paths); one cycle of arbitration latency IDLE->CMD.
REQ-021 SHALL permit the next arbitration in the cycle after a transaction's last handshake (IDLE lasts at least one cycle).
REQ-022 SHALL not re-order or drop words; stalls (valid or ready low) hold counter and state.
REQ-023 SHALL treat the 32-bit length unsigned; counter width 32, no overflow possible.

Reset
REQ-024 SHALL, while reset_n=0 at a clock edge: state=IDLE, rr_ptr=0, grant_id=0, counter=0; all valid/ready outputs 0, busy=0, data outputs 0.
REQ-025 SHALL abandon any in-flight transaction on reset with no further handshakes; requesters are responsible for flushing.

Verification
REQ-026 Single write: port 2 cmd {0, 0x100, 4} + 4 words -> mem_cmd_data identical, 4 words on mem_write in order, busy drops after 4th handshake.
REQ-027 Round robin: ports 0,1,3 request simultaneously from reset -> grants in order 0,1,3, then 0 again if it re-requests while 1 also requests -> 1 first.
REQ-028 Read with backpressure: port 1 read length 3, req_rd_ready toggled 1/0 -> only port 1 sees req_rd_valid, exactly 3 words, mem_read_ready mirrors toggling.
REQ-029 Zero length: port 0 cmd {1, 0x0, 0} -> one mem_cmd handshake, no mem_read_ready assertion, IDLE next cycle.
REQ-030 Reset mid-write: reset_n=0 after 2 of 8 words -> next cycle all valids 0, busy=0, rr_ptr=0; new write after release completes normally.
REQ-031 Isolation: non-granted ports drive req_wr_valid=1 throughout -> their req_wr_ready stays 0 and their data never appears on mem_write_data.
